// File: rtl/intersection_sequencer.sv
// Two-approach traffic-light sequencer with all-red clearance and a pedestrian walk phase.
// Define PREEMPT_EN to add the preempt input (forces yellow, then holds all-red while asserted).
//
// state   | meaning
// NS_G    | north-south green, east-west red
// NS_Y    | north-south yellow, east-west red
// AR1     | all red, clearing north-south traffic
// EW_G    | east-west green, north-south red
// EW_Y    | east-west yellow, north-south red
// AR2     | all red, clearing east-west traffic
// WALK    | all red, pedestrian walk lamp lit
module intersection_sequencer #(
    parameter int GT = 15,
    parameter int YT = 1,
    parameter int AR = 1,
    parameter int WT = 3
) (
    input  logic       clk,
    input  logic       reset,
`ifdef PREEMPT_EN
    input  logic       preempt,
`endif
    input  logic       tick,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NS_G = 3'd0,
        S_NS_Y = 3'd1,
        S_AR1  = 3'd2,
        S_EW_G = 3'd3,
        S_EW_Y = 3'd4,
        S_AR2  = 3'd5,
        S_WALK = 3'd6
    } state_t;

    localparam logic [4:0] GT_M1 = 5'(GT - 1);
    localparam logic [4:0] YT_M1 = 5'(YT - 1);
    localparam logic [4:0] AR_M1 = 5'(AR - 1);
    localparam logic [4:0] WT_M1 = 5'(WT - 1);

    state_t     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic       ped_pend_q, ped_pend_d;
    logic       ped_ack_q, ped_ack_d;
    logic [4:0] dur_m1;
    logic       enter_walk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_NS_G;
            count_q    <= 5'd0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dur_m1  = GT_M1;

        case (state_q)
            S_NS_G, S_EW_G: dur_m1 = GT_M1;
            S_NS_Y, S_EW_Y: dur_m1 = YT_M1;
            S_AR1, S_AR2:   dur_m1 = AR_M1;
            S_WALK:         dur_m1 = WT_M1;
            default:        dur_m1 = 5'd0;
        endcase

        if (tick) begin
            if (count_q == dur_m1) begin
                count_d = 5'd0;
                case (state_q)
                    S_NS_G:  state_d = S_NS_Y;
                    S_NS_Y:  state_d = S_AR1;
                    S_AR1:   state_d = S_EW_G;
                    S_EW_G:  state_d = S_EW_Y;
                    S_EW_Y:  state_d = S_AR2;
                    // A request landing on the exit edge itself still earns the walk.
                    S_AR2:   state_d = (ped_pend_q || ped_req) ? S_WALK : S_NS_G;
                    S_WALK:  state_d = S_NS_G;
                    default: state_d = S_NS_G;
                endcase
            end else begin
                count_d = count_q + 5'd1;
            end
        end

`ifdef PREEMPT_EN
        // Preempt cuts greens short on a tick and parks in all-red with a fresh dwell count.
        if (preempt) begin
            if (tick && state_q == S_NS_G) begin
                state_d = S_NS_Y;
                count_d = 5'd0;
            end else if (tick && state_q == S_EW_G) begin
                state_d = S_EW_Y;
                count_d = 5'd0;
            end else if (state_q == S_AR1 || state_q == S_AR2) begin
                state_d = state_q;
                count_d = 5'd0;
            end
        end
`endif
    end

    assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

    // A fresh request wins over the clear so a request on the WALK entry edge is kept.
    assign ped_pend_d = ped_req | (ped_pend_q & ~enter_walk);
    assign ped_ack_d  = enter_walk;

    always_comb begin
        ns_green  = 1'b0;
        ns_yellow = 1'b0;
        ns_red    = 1'b1;
        ew_green  = 1'b0;
        ew_yellow = 1'b0;
        ew_red    = 1'b1;
        walk      = 1'b0;
        case (state_q)
            S_NS_G: begin
                ns_green = 1'b1;
                ns_red   = 1'b0;
            end
            S_NS_Y: begin
                ns_yellow = 1'b1;
                ns_red    = 1'b0;
            end
            S_EW_G: begin
                ew_green = 1'b1;
                ew_red   = 1'b0;
            end
            S_EW_Y: begin
                ew_yellow = 1'b1;
                ew_red    = 1'b0;
            end
            S_WALK:  walk = 1'b1;
            default: ;
        endcase
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Scoreboard bench for intersection_sequencer: directed timelines push expected per-cycle
// outputs; a monitor pops and compares one entry per clock. Define PREEMPT_EN for the preempt case.
module tb_intersection_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic       walk;
    logic [2:0] phase;
`ifdef PREEMPT_EN
    logic       preempt = 1'b0;
    logic       pre_v = 1'b0;
`endif

    typedef struct {
        logic [2:0] ph;
        logic       ack;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string scen = "init";

    always #5 clk = ~clk;

    intersection_sequencer dut (
        .clk       (clk),
        .reset     (reset),
`ifdef PREEMPT_EN
        .preempt   (preempt),
`endif
        .tick      (tick),
        .ped_req   (ped_req),
        .ped_ack   (ped_ack),
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .walk      (walk),
        .phase     (phase)
    );

    // Lamp vector {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} for each phase code.
    function automatic logic [6:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 7'b100_001_0;
            3'd1:    return 7'b010_001_0;
            3'd3:    return 7'b001_100_0;
            3'd4:    return 7'b001_010_0;
            3'd6:    return 7'b001_001_1;
            default: return 7'b001_001_0;
        endcase
    endfunction

    // Monitor: outputs seen during the cycle whose inputs were just applied.
    initial begin
        exp_t       e;
        logic [6:0] act_l;
        logic [6:0] exp_l;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                act_l = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk};
                exp_l = lamps_for(e.ph);
                n_cmp++;
                if (phase !== e.ph || act_l !== exp_l || ped_ack !== e.ack) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got phase=%0d lamps=%b ack=%b, expected phase=%0d lamps=%b ack=%b",
                             scen, $time, phase, act_l, ped_ack, e.ph, exp_l, e.ack);
                end
            end
        end
    end

    task automatic cyc(input bit rst, input bit tk, input bit pr, input logic [2:0] ph, input bit ack);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        tick    = tk;
        ped_req = pr;
`ifdef PREEMPT_EN
        preempt = pre_v;
`endif
        e.ph  = ph;
        e.ack = ack;
        exp_q.push_back(e);
    endtask

    // n ticks of phase ph, one tick every per clocks; ped_req on cycle pr_at of the dwell.
    task automatic dwell(input logic [2:0] ph, input int n, input int per, input int pr_at, input bit ack);
        int c;
        c = 0;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < per; k++) begin
                cyc(1'b0, k == per - 1, c == pr_at, ph, ack && (c == 0));
                c++;
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int guard;

        scen = "period_tick4";
        do_reset();
        dwell(3'd0, 15, 4, -1, 1'b0);
        dwell(3'd1, 1, 4, -1, 1'b0);
        dwell(3'd2, 1, 4, -1, 1'b0);
        dwell(3'd3, 15, 4, -1, 1'b0);
        dwell(3'd4, 1, 4, -1, 1'b0);
        dwell(3'd5, 1, 4, -1, 1'b0);
        dwell(3'd0, 2, 4, -1, 1'b0);

        scen = "walk_after_ew";
        do_reset();
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, 5, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, -1, 1'b0);
        dwell(3'd6, 3, 1, -1, 1'b1);
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, -1, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, -1, 1'b0);
        dwell(3'd0, 2, 1, -1, 1'b0);

        scen = "req_on_walk_entry";
        do_reset();
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, 2, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, 0, 1'b0);
        dwell(3'd6, 3, 1, -1, 1'b1);
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, -1, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, -1, 1'b0);
        dwell(3'd6, 3, 1, -1, 1'b1);
        dwell(3'd0, 2, 1, -1, 1'b0);

        scen = "req_on_ar2_exit";
        do_reset();
        dwell(3'd0, 15, 2, -1, 1'b0);
        dwell(3'd1, 1, 2, -1, 1'b0);
        dwell(3'd2, 1, 2, -1, 1'b0);
        dwell(3'd3, 15, 2, -1, 1'b0);
        dwell(3'd4, 1, 2, -1, 1'b0);
        dwell(3'd5, 1, 2, 1, 1'b0);
        dwell(3'd6, 3, 2, 2, 1'b1);
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, -1, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, -1, 1'b0);
        dwell(3'd6, 3, 1, -1, 1'b1);
        dwell(3'd0, 2, 1, -1, 1'b0);

        scen = "reset_mid_ew";
        do_reset();
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 7, 1, 3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        dwell(3'd0, 15, 1, -1, 1'b0);
        dwell(3'd1, 1, 1, -1, 1'b0);
        dwell(3'd2, 1, 1, -1, 1'b0);
        dwell(3'd3, 15, 1, -1, 1'b0);
        dwell(3'd4, 1, 1, -1, 1'b0);
        dwell(3'd5, 1, 1, -1, 1'b0);
        dwell(3'd0, 1, 1, -1, 1'b0);

`ifdef PREEMPT_EN
        scen = "preempt_ns";
        do_reset();
        dwell(3'd0, 3, 1, -1, 1'b0);
        pre_v = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        pre_v = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        dwell(3'd3, 3, 1, -1, 1'b0);
`endif

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
